alu_core: RTL and testbench
===========================

Name: alu_core

Overview:
- 32-bit combinational integer ALU for the MIPS-style datapath, with an R-type `funct` field selecting the operation.
- Produces a 32-bit result plus zero/negative/positive status flags, used by the execute stage and by branch evaluation.
- Contains HI/LO registers, clocked on `clk`, for multiply/divide and the MFHI/MFLO/MTHI/MTLO operations.

Parameters:
- None (all widths fixed at 32-bit data, 5-bit shift amount, 6-bit funct).

Ports:
- clk  input  1  system clock; HI/LO update on rising edge
- rst  input  1  asynchronous, active-high reset; clears HI/LO
- dataIn0  input  32  operand A (rs)
- dataIn1  input  32  operand B (rt); the shifted operand for all shifts
- shamt  input  5  immediate shift amount for SLL/SRL/SRA
- funct  input  6  operation select (MIPS R-type funct encoding)
- result  output  32  operation result
- outputZero  output  1  result == 0
- outputNegative  output  1  result[31] == 1
- outputPositive  output  1  result != 0 and result[31] == 0

Behaviour:
- `result` and all flags are purely combinational from the inputs and HI/LO. They are valid within the same cycle the inputs change, with zero clock latency.
- Flags are always derived from the final `result` as a signed value. Exactly one of zero/negative/positive is 1 at any time.
- funct decode (binary), operation and result:
  - 000000 SLL: dataIn1 << shamt
  - 000010 SRL: dataIn1 >> shamt, logical
  - 000011 SRA: dataIn1 >>> shamt, arithmetic
  - 000100 SLLV: dataIn1 << dataIn0[4:0]
  - 000110 SRLV: logical right shift by dataIn0[4:0]
  - 000111 SRAV: arithmetic right shift by dataIn0[4:0]
  - 010000 MFHI: result = HI
  - 010010 MFLO: result = LO
  - 010001 MTHI: result = 0; HI <= dataIn0 at next posedge
  - 010011 MTLO: result = 0; LO <= dataIn0 at next posedge
  - 011000 MULT: result = 0; {HI,LO} <= signed 64-bit product
  - 011001 MULTU: result = 0; {HI,LO} <= unsigned 64-bit product
  - 011010 DIV: result = 0; LO <= signed quotient, HI <= signed remainder (remainder takes the sign of the dividend, quotient truncates toward zero)
  - 011011 DIVU: result = 0; unsigned quotient/remainder
  - 100000 ADD / 100001 ADDU: dataIn0 + dataIn1, modulo 2^32; no overflow trap or flag
  - 100010 SUB / 100011 SUBU: dataIn0 - dataIn1, modulo 2^32
  - 100100 AND, 100101 OR, 100110 XOR, 100111 NOR: bitwise
  - 101010 SLT: 1 if signed(dataIn0) < signed(dataIn1), else 0
  - 101011 SLTU: 1 if unsigned compare is less, else 0
  - any other code: result = 0, which gives outputZero = 1
- Shift amounts 0..31 are legal; shift by 0 passes dataIn1 unchanged.
- DIV/DIVU with dataIn1 == 0: HI and LO hold their previous values.
- DIV with 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0 (wrap).
- HI/LO timing:
  - Written only on the rising `clk` edge while the write-type funct is present.
  - Hold their value at all other times.
- Reset:
  - `rst` high clears HI and LO to 0 immediately, independent of `clk`. They stay 0 while `rst` is high.
  - `result` and the flags have no reset state; they follow the inputs combinationally even during reset.
- Multiply and divide may be implemented combinationally as single-cycle operations; no stall or handshake is provided.

Test Plan:
- ADD: dataIn0=5, dataIn1=7, funct=100000 -> result=12, Positive=1. Then dataIn0=0x7FFFFFFF, dataIn1=1 -> result=0x80000000, Negative=1.
- SUB: dataIn0=3, dataIn1=3, funct=100010 -> result=0, Zero=1. Then dataIn0=2, dataIn1=5 -> result=0xFFFFFFFD, Negative=1.
- Shifts on dataIn1=0x80000010:
  - SLL, shamt=4 -> 0x00000100
  - SRL, shamt=4 -> 0x08000001
  - SRA, shamt=4 -> 0xF8000001
  - SRAV with dataIn0=31 -> 0xFFFFFFFF
- SLT/SLTU: dataIn0=0xFFFFFFFF, dataIn1=1 -> SLT result=1 (Positive); SLTU result=0 (Zero).
- MULT then MFHI/MFLO: dataIn0=-3, dataIn1=4, MULT across a posedge; then MFLO -> 0xFFFFFFF4 and MFHI -> 0xFFFFFFFF.
- DIV then reset:
  - DIV 7 / -2 -> LO=0xFFFFFFFD, HI=1.
  - DIVU by 0 -> HI/LO unchanged.
  - Assert rst mid-cycle -> MFLO returns 0 immediately.
- Undefined funct=111111 -> result=0, Zero=1, Negative=0, Positive=0.

Source files
------------

// File: rtl/alu_core_if.sv
// Operand/result bundle between the execute stage and the integer ALU.
// The stage driving operands uses master; the ALU uses slave.
interface alu_core_if;
    logic [31:0] dataIn0;
    logic [31:0] dataIn1;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] result;
    logic        outputZero;
    logic        outputNegative;
    logic        outputPositive;

    modport master (
        output dataIn0, dataIn1, shamt, funct,
        input  result, outputZero, outputNegative, outputPositive
    );

    modport slave (
        input  dataIn0, dataIn1, shamt, funct,
        output result, outputZero, outputNegative, outputPositive
    );
endinterface

// File: rtl/alu_core.sv
// 32-bit MIPS R-type integer ALU.
// The result path is combinational; HI/LO hold multiply/divide results.
module alu_core (
    input  logic       clk,
    input  logic       rst,
    alu_core_if.slave  bus
);
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_SLLV  = 6'b000100;
    localparam logic [5:0] F_SRLV  = 6'b000110;
    localparam logic [5:0] F_SRAV  = 6'b000111;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    logic [31:0] a_s;
    logic [31:0] b_s;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] result_s;

    assign a_s = bus.dataIn0;
    assign b_s = bus.dataIn1;

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    logic [63:0] smul_s;
    logic [63:0] umul_s;
    assign smul_s = {{32{a_s[31]}}, a_s} * {{32{b_s[31]}}, b_s};
    assign umul_s = {32'd0, a_s} * {32'd0, b_s};

    // Signed divide done on magnitudes so MIN/-1 simply wraps instead of overflowing.
    logic        div_zero_s;
    logic [31:0] b_safe_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [31:0] sq_mag_s;
    logic [31:0] sr_mag_s;
    logic [31:0] squot_s;
    logic [31:0] srem_s;
    logic [31:0] uquot_s;
    logic [31:0] urem_s;

    assign div_zero_s = (b_s == 32'd0);
    assign b_safe_s   = div_zero_s ? 32'd1 : b_s;
    assign a_mag_s    = a_s[31] ? (32'd0 - a_s) : a_s;
    assign b_mag_s    = b_safe_s[31] ? (32'd0 - b_safe_s) : b_safe_s;
    assign sq_mag_s   = a_mag_s / b_mag_s;
    assign sr_mag_s   = a_mag_s % b_mag_s;
    assign squot_s    = (a_s[31] ^ b_s[31]) ? (32'd0 - sq_mag_s) : sq_mag_s;
    assign srem_s     = a_s[31] ? (32'd0 - sr_mag_s) : sr_mag_s;
    assign uquot_s    = a_s / b_safe_s;
    assign urem_s     = a_s % b_safe_s;

    // Result mux; HI/LO writers and unknown codes return zero.
    always_comb begin
        result_s = 32'd0;
        case (bus.funct)
            F_SLL:   result_s = b_s << bus.shamt;
            F_SRL:   result_s = b_s >> bus.shamt;
            F_SRA:   result_s = $unsigned($signed(b_s) >>> bus.shamt);
            F_SLLV:  result_s = b_s << a_s[4:0];
            F_SRLV:  result_s = b_s >> a_s[4:0];
            F_SRAV:  result_s = $unsigned($signed(b_s) >>> a_s[4:0]);
            F_MFHI:  result_s = hi_q;
            F_MFLO:  result_s = lo_q;
            F_ADD,
            F_ADDU:  result_s = a_s + b_s;
            F_SUB,
            F_SUBU:  result_s = a_s - b_s;
            F_AND:   result_s = a_s & b_s;
            F_OR:    result_s = a_s | b_s;
            F_XOR:   result_s = a_s ^ b_s;
            F_NOR:   result_s = ~(a_s | b_s);
            F_SLT:   result_s = {31'd0, ($signed(a_s) < $signed(b_s))};
            F_SLTU:  result_s = {31'd0, (a_s < b_s)};
            default: result_s = 32'd0;
        endcase
    end

    assign bus.result         = result_s;
    assign bus.outputZero     = (result_s == 32'd0);
    assign bus.outputNegative = result_s[31];
    assign bus.outputPositive = (result_s != 32'd0) && !result_s[31];

    // HI/LO next-state; divide by zero leaves both untouched.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        case (bus.funct)
            F_MTHI:  hi_d = a_s;
            F_MTLO:  lo_d = a_s;
            F_MULT: begin
                hi_d = smul_s[63:32];
                lo_d = smul_s[31:0];
            end
            F_MULTU: begin
                hi_d = umul_s[63:32];
                lo_d = umul_s[31:0];
            end
            F_DIV: begin
                if (!div_zero_s) begin
                    hi_d = srem_s;
                    lo_d = squot_s;
                end else begin
                    hi_d = hi_q;
                    lo_d = lo_q;
                end
            end
            F_DIVU: begin
                if (!div_zero_s) begin
                    hi_d = urem_s;
                    lo_d = uquot_s;
                end else begin
                    hi_d = hi_q;
                    lo_d = lo_q;
                end
            end
            default: begin
                hi_d = hi_q;
                lo_d = lo_q;
            end
        endcase
    end

    // HI/LO registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end
endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: driver pushes model predictions,
// a negedge monitor pops and compares them with the ALU outputs.
module tb_alu_core;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    alu_core_if bus ();

    alu_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [34:0] exp;
        string       nm;
    } sb_t;

    sb_t         sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    // Reference result straight from the instruction definitions.
    function automatic logic [31:0] model_res(input logic [31:0] a, input logic [31:0] b,
                                              input logic [4:0] sh, input logic [5:0] f);
        int t;
        case (f)
            6'h00: return b << sh;
            6'h02: return b >> sh;
            6'h03: begin t = $signed(b); t = t >>> sh; return t; end
            6'h04: return b << a[4:0];
            6'h06: return b >> a[4:0];
            6'h07: begin t = $signed(b); t = t >>> a[4:0]; return t; end
            6'h10: return m_hi;
            6'h12: return m_lo;
            6'h20, 6'h21: return a + b;
            6'h22, 6'h23: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h26: return a ^ b;
            6'h27: return ~(a | b);
            6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h2B: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Apply the HI/LO side effect that the coming clock edge will perform.
    task automatic commit(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f);
        longint sa, sb, prod, q, r;
        logic [63:0] up;
        sa = $signed(a);
        sb = $signed(b);
        if (rst) begin
            m_hi = 32'd0;
            m_lo = 32'd0;
        end else begin
            case (f)
                6'h11: m_hi = a;
                6'h13: m_lo = a;
                6'h18: begin prod = sa * sb; m_hi = prod[63:32]; m_lo = prod[31:0]; end
                6'h19: begin up = {32'd0, a} * {32'd0, b}; m_hi = up[63:32]; m_lo = up[31:0]; end
                6'h1A: if (b != 32'd0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
                6'h1B: if (b != 32'd0) begin m_lo = a / b; m_hi = a % b; end
                default: ;
            endcase
        end
    endtask

    task automatic push(input string nm);
        sb_t         e;
        logic [31:0] r;
        r     = model_res(bus.dataIn0, bus.dataIn1, bus.shamt, bus.funct);
        e.exp = {r, (r == 32'd0), ($signed(r) < 0), ($signed(r) > 0)};
        e.nm  = nm;
        sb_q.push_back(e);
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                      input logic [5:0] f, input string nm);
        @(posedge clk);
        #1;
        bus.dataIn0 = a;
        bus.dataIn1 = b;
        bus.shamt   = sh;
        bus.funct   = f;
        push(nm);
        commit(a, b, f);
    endtask

    // Monitor: the combinational result is settled by the falling edge.
    always @(negedge clk) begin : monitor
        sb_t         e;
        logic [34:0] got;
        if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            got = {bus.result, bus.outputZero, bus.outputNegative, bus.outputPositive};
            n_checks++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got result=%h z/n/p=%b, expected result=%h z/n/p=%b",
                         e.nm, got[34:3], got[2:0], e.exp[34:3], e.exp[2:0]);
            end
        end
    end

    logic [5:0] codes [24] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h11,
                               6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h20, 6'h21,
                               6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int waited;
        logic [5:0] f;
        rst         = 1'b1;
        bus.dataIn0 = 32'd0;
        bus.dataIn1 = 32'd0;
        bus.shamt   = 5'd0;
        bus.funct   = 6'h3F;

        op(32'd0, 32'd0, 5'd0, 6'h10, "reset_mfhi");
        op(32'd0, 32'd0, 5'd0, 6'h12, "reset_mflo");
        op(32'h1234_5678, 32'd0, 5'd0, 6'h13, "reset_mtlo_blocked");
        op(32'd0, 32'd0, 5'd0, 6'h12, "reset_mflo_still0");
        @(posedge clk);
        #1 rst = 1'b0;

        op(32'd5, 32'd7, 5'd0, 6'h20, "add_5_7");
        op(32'h7FFF_FFFF, 32'd1, 5'd0, 6'h20, "add_wrap");
        op(32'd3, 32'd3, 5'd0, 6'h22, "sub_zero");
        op(32'd2, 32'd5, 5'd0, 6'h22, "sub_neg");
        op(32'd0, 32'h8000_0010, 5'd4, 6'h00, "sll4");
        op(32'd0, 32'h8000_0010, 5'd4, 6'h02, "srl4");
        op(32'd0, 32'h8000_0010, 5'd4, 6'h03, "sra4");
        op(32'd31, 32'h8000_0010, 5'd0, 6'h07, "srav31");
        op(32'd0, 32'h8000_0010, 5'd0, 6'h03, "sra0");
        op(32'd32, 32'hA5A5_0001, 5'd0, 6'h04, "sllv_0");
        op(32'hFFFF_FFFF, 32'd1, 5'd0, 6'h2A, "slt");
        op(32'hFFFF_FFFF, 32'd1, 5'd0, 6'h2B, "sltu");
        op(-32'sd3, 32'd4, 5'd0, 6'h18, "mult");
        op(32'd0, 32'd0, 5'd0, 6'h12, "mult_mflo");
        op(32'd0, 32'd0, 5'd0, 6'h10, "mult_mfhi");
        op(32'd7, -32'sd2, 5'd0, 6'h1A, "div_7_m2");
        op(32'd0, 32'd0, 5'd0, 6'h12, "div_mflo");
        op(32'd0, 32'd0, 5'd0, 6'h10, "div_mfhi");
        op(32'd9, 32'd0, 5'd0, 6'h1B, "divu_by0");
        op(32'd0, 32'd0, 5'd0, 6'h12, "divu0_mflo");
        op(32'd0, 32'd0, 5'd0, 6'h10, "divu0_mfhi");
        op(32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 6'h1A, "div_min_m1");
        op(32'd0, 32'd0, 5'd0, 6'h12, "divmin_mflo");
        op(32'd0, 32'd0, 5'd0, 6'h10, "divmin_mfhi");
        op(32'h1234_5678, 32'h9ABC_DEF0, 5'd0, 6'h3F, "undef_3f");

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) f = 6'($urandom);
            else f = codes[$urandom_range(0, 23)];
            op(rand_operand(), rand_operand(), 5'($urandom), f, "random");
        end

        // Asynchronous reset partway through a cycle while MFLO is selected.
        op(32'hCAFE_F00D, 32'd0, 5'd0, 6'h13, "pre_rst_mtlo");
        op(32'd0, 32'd0, 5'd0, 6'h12, "pre_rst_mflo");
        @(posedge clk);
        #1;
        bus.funct = 6'h12;
        #2;
        rst  = 1'b1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        push("midcycle_rst_mflo");
        op(32'hDEAD_BEEF, 32'd0, 5'd0, 6'h11, "rst_mthi_blocked");
        op(32'd0, 32'd0, 5'd0, 6'h10, "rst_mfhi");
        @(posedge clk);
        #1 rst = 1'b0;
        op(32'd0, 32'd0, 5'd0, 6'h12, "post_rst_mflo");

        waited = 0;
        while (sb_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
